// File: rtl/input_debounce_cond.sv
// Conditions the raw push button and mode switch for the traffic-light controller:
// two-flop synchronisation plus counter-based debounce per channel, and a press pulse.
module input_debounce_cond #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk_i,
  input  logic rst,
  input  logic button_raw_i,
  input  logic swap_raw_i,
  output logic button_level_o,
  output logic button_pulse_o,
  output logic swap_mode_o
);

  localparam int NCH = 2;
  localparam int CH_BTN = 0;
  localparam int CH_SWP = 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  logic [NCH-1:0]   raw_s;
  logic [NCH-1:0]   s1_q, s1_d;
  logic [NCH-1:0]   s2_q, s2_d;
  logic [NCH-1:0]   stable_q, stable_d;
  state_e           state_q [NCH];
  state_e           state_d [NCH];
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic             pulse_q, pulse_d;

  // Button polarity is normalised so that 1 always means pressed.
  assign raw_s[CH_BTN] = button_raw_i ^ BTN_ACTIVE_LOW;
  assign raw_s[CH_SWP] = swap_raw_i;

  // Synchroniser stages and the per-channel debounce FSM; channels never interact.
  always_comb begin
    s1_d     = raw_s;
    s2_d     = s1_q;
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (s2_q[i] != stable_q[i]) begin
            state_d[i] = ST_COUNT;
            cnt_d[i]   = CNT_ONE;
          end else begin
            cnt_d[i]   = CNT_ZERO;
          end
        end
        ST_COUNT: begin
          if (s2_q[i] == stable_q[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = CNT_ZERO;
          end else if (cnt_q[i] >= CNT_LAST) begin
            // >= keeps the counter from ever running past the terminal value
            stable_d[i] = s2_q[i];
            state_d[i]  = ST_IDLE;
            cnt_d[i]    = CNT_ZERO;
          end else begin
            cnt_d[i]    = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = CNT_ZERO;
        end
      endcase
    end
    pulse_d = stable_d[CH_BTN] & ~stable_q[CH_BTN];
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      s1_q     <= {NCH{1'b0}};
      s2_q     <= {NCH{1'b0}};
      stable_q <= {NCH{1'b0}};
      pulse_q  <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= CNT_ZERO;
      end
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign button_level_o = stable_q[CH_BTN];
  assign swap_mode_o    = stable_q[CH_SWP];
  assign button_pulse_o = pulse_q;

endmodule

// File: tb/tb_input_debounce_cond.sv
// Scoreboard bench for input_debounce_cond: stimulus queues expected output events
// (edge number and value); a negedge monitor pops and compares on every output change.
module tb_input_debounce_cond;

  logic clk_i = 1'b0;
  logic rst = 1'b1;
  logic button_raw_i = 1'b1;
  logic swap_raw_i = 1'b0;
  logic button_level_o, button_pulse_o, swap_mode_o;

  int ecount = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic prev_btn = 1'b0;
  logic prev_swp = 1'b0;

  typedef struct {
    int   cyc;
    logic val;
  } exp_t;

  exp_t q_btn[$];
  exp_t q_swp[$];
  int   q_pls[$];

  input_debounce_cond #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(4),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_i(clk_i),
    .rst(rst),
    .button_raw_i(button_raw_i),
    .swap_raw_i(swap_raw_i),
    .button_level_o(button_level_o),
    .button_pulse_o(button_pulse_o),
    .swap_mode_o(swap_mode_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) ecount <= ecount + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecount);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic exp_btn(input int c, input logic v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    q_btn.push_back(e);
  endtask

  task automatic exp_swp(input int c, input logic v);
    exp_t e;
    e.cyc = c;
    e.val = v;
    q_swp.push_back(e);
  endtask

  // Monitor: every observed output event must match the head of its queue.
  always @(negedge clk_i) begin
    exp_t e;
    if (mon_en) begin
      if (button_level_o !== prev_btn) begin
        if (q_btn.size() == 0) begin
          chk("btn_level_unexpected", ecount, -1);
        end else begin
          e = q_btn.pop_front();
          chk("btn_level_edge", ecount, e.cyc);
          chk("btn_level_value", int'(button_level_o), int'(e.val));
        end
      end
      if (swap_mode_o !== prev_swp) begin
        if (q_swp.size() == 0) begin
          chk("swap_mode_unexpected", ecount, -1);
        end else begin
          e = q_swp.pop_front();
          chk("swap_mode_edge", ecount, e.cyc);
          chk("swap_mode_value", int'(swap_mode_o), int'(e.val));
        end
      end
      if (button_pulse_o !== 1'b0) begin
        if (q_pls.size() == 0) begin
          chk("btn_pulse_unexpected", ecount, -1);
        end else begin
          chk("btn_pulse_edge", ecount, q_pls.pop_front());
        end
      end
    end
    prev_btn = button_level_o;
    prev_swp = swap_mode_o;
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_btn_level", int'(button_level_o), 0);
    chk("rst_btn_pulse", int'(button_pulse_o), 0);
    chk("rst_swap_mode", int'(swap_mode_o), 0);
    rst = 1'b0;
    repeat (4) tick();
    mon_en = 1'b1;

    // Single press held 10 cycles, then release
    n = ecount; button_raw_i = 1'b0;
    exp_btn(n + 6, 1'b1); q_pls.push_back(n + 6);
    repeat (10) tick();
    n = ecount; button_raw_i = 1'b1;
    exp_btn(n + 6, 1'b0);
    repeat (10) tick();

    // Bounces shorter than the debounce window are never accepted
    repeat (5) begin
      button_raw_i = 1'b0;
      repeat (3) tick();
      button_raw_i = 1'b1;
      repeat (3) tick();
    end
    repeat (6) tick();
    chk("bounce_level", int'(button_level_o), 0);

    // Long hold, release, short gap, second press: exactly two pulses
    n = ecount; button_raw_i = 1'b0;
    exp_btn(n + 6, 1'b1); q_pls.push_back(n + 6);
    repeat (50) tick();
    n = ecount; button_raw_i = 1'b1;
    exp_btn(n + 6, 1'b0);
    repeat (8) tick();
    n = ecount; button_raw_i = 1'b0;
    exp_btn(n + 6, 1'b1); q_pls.push_back(n + 6);
    repeat (10) tick();
    n = ecount; button_raw_i = 1'b1;
    exp_btn(n + 6, 1'b0);
    repeat (10) tick();

    // Swap switch and button one cycle apart; swap then held ~100 cycles
    n = ecount; swap_raw_i = 1'b1;
    exp_swp(n + 6, 1'b1);
    tick();
    n = ecount; button_raw_i = 1'b0;
    exp_btn(n + 6, 1'b1); q_pls.push_back(n + 6);
    repeat (10) tick();
    n = ecount; button_raw_i = 1'b1;
    exp_btn(n + 6, 1'b0);
    repeat (89) tick();
    chk("swap_long_hold", int'(swap_mode_o), 1);
    n = ecount; swap_raw_i = 1'b0;
    exp_swp(n + 6, 1'b0);
    repeat (10) tick();

    // Reset while the press count is at 2; button stays held afterwards
    n = ecount; button_raw_i = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("midrst_btn_level", int'(button_level_o), 0);
    chk("midrst_btn_pulse", int'(button_pulse_o), 0);
    chk("midrst_swap_mode", int'(swap_mode_o), 0);
    rst = 1'b0;
    n = ecount;
    exp_btn(n + 6, 1'b1); q_pls.push_back(n + 6);
    repeat (12) tick();
    n = ecount; button_raw_i = 1'b1;
    exp_btn(n + 6, 1'b0);
    repeat (10) tick();

    chk("btn_level_pending", q_btn.size(), 0);
    chk("swap_mode_pending", q_swp.size(), 0);
    chk("btn_pulse_pending", q_pls.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
